// File: rtl/timer_sequencer_pkg.sv
// timer_sequencer_pkg: state encoding and button indices shared by the timer sequencer
package timer_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;
    localparam int BTN_START = 0;
    localparam int BTN_CLR   = 1;
    localparam int BTN_SEC   = 2;
    localparam int BTN_MIN   = 3;
endpackage

// File: rtl/press_repeat.sv
// press_repeat: press edge detect plus hold timer producing auto-repeat pulses
module press_repeat #(
    parameter int REPEAT_DLY = 12587500,
    parameter int REPEAT_PER = 2517500
) (
    input  logic MCLK,
    input  logic RST,
    input  logic BTN_N,
    input  logic ENABLE,
    output logic PULSE
);
    localparam int W = $clog2(REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1;
    logic         prs_q;
    logic         armed_q, armed_d;
    logic [W-1:0] tmr_q, tmr_d;
    logic         press, rep;
    // prs_q holds the pressed level; resetting it to pressed hides a button held through reset
    assign press = ~BTN_N & ~prs_q;
    assign PULSE = press | (rep & ENABLE);
    // hold timer: armed only by a real press, first repeat after REPEAT_DLY held cycles, then every REPEAT_PER
    always_comb begin
        tmr_d   = tmr_q;
        armed_d = armed_q;
        rep     = 1'b0;
        if (BTN_N) begin
            armed_d = 1'b0;
            tmr_d   = '0;
        end else if (press) begin
            armed_d = 1'b1;
            tmr_d   = W'(REPEAT_DLY - 1);
        end else if (armed_q) begin
            rep   = (tmr_q == '0);
            tmr_d = (tmr_q == '0) ? W'(REPEAT_PER - 1) : tmr_q - 1'b1;
        end
    end
    // history and timer registers
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            prs_q   <= 1'b1;
            armed_q <= 1'b0;
            tmr_q   <= '0;
        end else begin
            prs_q   <= ~BTN_N;
            armed_q <= armed_d;
            tmr_q   <= tmr_d;
        end
    end
endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: STOP/RUN/PAUSE/ALARM control FSM driving the BCD countdown counter chain
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int REPEAT_DLY  = 12587500,
    parameter int REPEAT_PER  = 2517500,
    parameter int ALARM_TICKS = 10
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic [3:0] BTD_N,
    input  logic       TICK,
    input  logic [3:0] MIN_1,
    input  logic [3:0] MIN_0,
    input  logic [3:0] SEC_1,
    input  logic [3:0] SEC_0,
    output logic       INC_SEC,
    output logic       INC_MIN,
    output logic       DEC_SEC,
    output logic       CLR,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       BLANK,
    output logic [1:0] STATE
);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    state_e        state_q, state_d;
    logic [1:0]    prs_q;
    logic          tick_q;
    logic          inc_sec_q, inc_sec_d, inc_min_q, inc_min_d;
    logic          dec_sec_q, dec_sec_d, clr_q, clr_d;
    logic          blank_q, blank_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          p0, p1, p2, p3, tick, set_en;
    logic          zero, one, full_sec, full_min;
    assign p0       = ~BTD_N[BTN_START] & ~prs_q[0];
    assign p1       = ~BTD_N[BTN_CLR] & ~prs_q[1];
    assign tick     = TICK & ~tick_q;
    assign set_en   = (state_q == ST_STOP) || (state_q == ST_PAUSE);
    assign zero     = {MIN_1, MIN_0, SEC_1, SEC_0} == 16'h0000;
    assign one      = {MIN_1, MIN_0, SEC_1, SEC_0} == 16'h0001;
    assign full_sec = {MIN_1, MIN_0, SEC_1, SEC_0} == 16'h9999;
    assign full_min = {MIN_1, MIN_0} == 8'h99;
    assign INC_SEC  = inc_sec_q;
    assign INC_MIN  = inc_min_q;
    assign DEC_SEC  = dec_sec_q;
    assign CLR      = clr_q;
    assign BLANK    = blank_q;
    assign STATE    = state_q;
    assign RUNNING  = state_q == ST_RUN;
    assign ALARM    = state_q == ST_ALARM;
    press_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_sec (
        .MCLK(MCLK), .RST(RST), .BTN_N(BTD_N[BTN_SEC]),
        .ENABLE(set_en & BTD_N[BTN_MIN]), .PULSE(p2)
    );
    press_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_min (
        .MCLK(MCLK), .RST(RST), .BTN_N(BTD_N[BTN_MIN]),
        .ENABLE(set_en), .PULSE(p3)
    );
    // next state and strobes; event priority BT1 > BT0 > tick > BT3 > BT2
    always_comb begin
        state_d   = state_q;
        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        dec_sec_d = 1'b0;
        clr_d     = 1'b0;
        blank_d   = blank_q;
        acnt_d    = acnt_q;
        case (state_q)
            ST_STOP, ST_PAUSE: begin
                if (p1) begin
                    clr_d   = 1'b1;
                    state_d = ST_STOP;
                end else if (p0) state_d = zero ? ST_STOP : ST_RUN;
                else if (p3) inc_min_d = ~full_min;
                else if (p2) inc_sec_d = ~full_sec;
            end
            ST_RUN: begin
                if (p1) begin
                    clr_d   = 1'b1;
                    state_d = ST_STOP;
                end else if (p0) state_d = ST_PAUSE;
                else if (tick) begin
                    dec_sec_d = ~zero;
                    if (zero || one) begin
                        state_d = ST_ALARM;
                        blank_d = 1'b0;
                        acnt_d  = '0;
                    end
                end
            end
            ST_ALARM: begin
                if (p1 || p0) begin
                    state_d = ST_STOP;
                    blank_d = 1'b0;
                end else if (tick) begin
                    acnt_d  = acnt_q + 1'b1;
                    state_d = (acnt_q == AW'(ALARM_TICKS - 1)) ? ST_STOP : ST_ALARM;
                    blank_d = (acnt_q == AW'(ALARM_TICKS - 1)) ? 1'b0 : ~blank_q;
                end else if (p3 || p2) begin
                    state_d = ST_STOP;
                    blank_d = 1'b0;
                end
            end
        endcase
    end
    // state, history and registered outputs
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_STOP;
            prs_q     <= 2'b11;
            tick_q    <= 1'b1;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
            dec_sec_q <= 1'b0;
            clr_q     <= 1'b0;
            blank_q   <= 1'b0;
            acnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            prs_q     <= ~BTD_N[1:0];
            tick_q    <= TICK;
            inc_sec_q <= inc_sec_d;
            inc_min_q <= inc_min_d;
            dec_sec_q <= dec_sec_d;
            clr_q     <= clr_d;
            blank_q   <= blank_d;
            acnt_q    <= acnt_d;
        end
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed scenarios plus randomized events against a decimal-counter reference model
module tb_timer_sequencer;
    logic       MCLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] BTD_N = 4'hF;
    logic       TICK = 1'b0;
    logic [3:0] MIN_1 = 4'd0, MIN_0 = 4'd0, SEC_1 = 4'd0, SEC_0 = 4'd0;
    logic       INC_SEC, INC_MIN, DEC_SEC, CLR, RUNNING, ALARM, BLANK;
    logic [1:0] STATE;
    int checks = 0;
    int failures = 0;

    timer_sequencer #(.REPEAT_DLY(8), .REPEAT_PER(4), .ALARM_TICKS(10)) dut (
        .MCLK(MCLK), .RST(RST), .BTD_N(BTD_N), .TICK(TICK),
        .MIN_1(MIN_1), .MIN_0(MIN_0), .SEC_1(SEC_1), .SEC_0(SEC_0),
        .INC_SEC(INC_SEC), .INC_MIN(INC_MIN), .DEC_SEC(DEC_SEC), .CLR(CLR),
        .RUNNING(RUNNING), .ALARM(ALARM), .BLANK(BLANK), .STATE(STATE)
    );

    always #5 MCLK = ~MCLK;

    task automatic set_digits(input int v);
        MIN_1 = 4'(v / 1000);
        MIN_0 = 4'((v / 100) % 10);
        SEC_1 = 4'((v / 10) % 10);
        SEC_0 = 4'(v % 10);
    endtask

    task automatic step(input logic [3:0] bn, input logic t);
        @(negedge MCLK);
        BTD_N = bn;
        TICK = t;
        @(posedge MCLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge MCLK);
        RST = 1'b1;
        BTD_N = 4'hF;
        TICK = 1'b0;
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge MCLK);
        set_digits(0);
        BTD_N = 4'b1011;
        TICK = 1'b1;
        RST = 1'b1;
        #1;
        checks++;
        if ({INC_SEC, INC_MIN, DEC_SEC, CLR, RUNNING, ALARM, BLANK, STATE} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {INC_SEC, INC_MIN, DEC_SEC, CLR, RUNNING, ALARM, BLANK, STATE});
        end
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(4'b1011, 1'b1);
            checks++;
            if ({INC_SEC, INC_MIN, DEC_SEC, CLR, STATE} !== 6'd0) begin
                failures++;
                $display("FAIL held_through_reset cyc=%0d got=%b want=0", i, {INC_SEC, INC_MIN, DEC_SEC, CLR, STATE});
            end
        end
        step(4'hF, 1'b0);
        step(4'b1011, 1'b0);
        checks++;
        if (INC_SEC !== 1'b1) begin
            failures++;
            $display("FAIL first_press got=%b want=1", INC_SEC);
        end
        step(4'hF, 1'b0);
        checks++;
        if (INC_SEC !== 1'b0) begin
            failures++;
            $display("FAIL press_one_cycle got=%b want=0", INC_SEC);
        end
    endtask

    task automatic test_run_alarm();
        set_digits(0);
        step(4'b1110, 1'b0);
        checks++;
        if (STATE !== 2'd0) begin
            failures++;
            $display("FAIL start_at_zero state=%0d want=0", STATE);
        end
        step(4'hF, 1'b0);
        set_digits(3);
        step(4'b1110, 1'b0);
        checks++;
        if (STATE !== 2'd1 || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL start_run state=%0d running=%b want=1/1", STATE, RUNNING);
        end
        step(4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_digits(3 - i);
            step(4'hF, 1'b1);
            checks++;
            if (DEC_SEC !== 1'b1 || STATE !== (i == 2 ? 2'd3 : 2'd1) || ALARM !== (i == 2) || RUNNING !== (i != 2)) begin
                failures++;
                $display("FAIL run_tick%0d dec=%b state=%0d alarm=%b running=%b", i, DEC_SEC, STATE, ALARM, RUNNING);
            end
            step(4'hF, 1'b0);
        end
        set_digits(0);
    endtask

    task automatic test_alarm();
        for (int i = 1; i <= 10; i++) begin
            step(4'hF, 1'b1);
            checks++;
            if (STATE !== (i == 10 ? 2'd0 : 2'd3) || BLANK !== (i == 10 ? 1'b0 : 1'(i % 2))) begin
                failures++;
                $display("FAIL alarm_tick%0d state=%0d blank=%b", i, STATE, BLANK);
            end
            step(4'hF, 1'b0);
        end
        set_digits(1);
        step(4'b1110, 1'b0);
        step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        step(4'hF, 1'b0);
        set_digits(0);
        checks++;
        if (STATE !== 2'd3) begin
            failures++;
            $display("FAIL alarm_reentry state=%0d want=3", STATE);
        end
        repeat (2) begin
            step(4'hF, 1'b1);
            step(4'hF, 1'b0);
        end
        step(4'b1011, 1'b0);
        checks++;
        if (STATE !== 2'd0 || BLANK !== 1'b0 || INC_SEC !== 1'b0) begin
            failures++;
            $display("FAIL alarm_abort state=%0d blank=%b inc=%b want=0/0/0", STATE, BLANK, INC_SEC);
        end
        step(4'hF, 1'b0);
        checks++;
        if (INC_SEC !== 1'b0) begin
            failures++;
            $display("FAIL alarm_abort_consumed inc=%b want=0", INC_SEC);
        end
    endtask

    task automatic test_repeat();
        int n;
        set_digits(0);
        n = 0;
        for (int h = 1; h <= 20; h++) begin
            step(4'b0111, 1'b0);
            n += int'(INC_MIN);
            checks++;
            if (INC_MIN !== (h == 1 || (h >= 9 && (h - 9) % 4 == 0))) begin
                failures++;
                $display("FAIL repeat_h%0d inc_min=%b", h, INC_MIN);
            end
        end
        step(4'hF, 1'b0);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL repeat_count got=%0d want=4", n);
        end
        set_digits(9900);
        n = 0;
        for (int h = 1; h <= 20; h++) begin
            step(4'b0111, 1'b0);
            n += int'(INC_MIN);
        end
        step(4'hF, 1'b0);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL repeat_saturate got=%0d want=0", n);
        end
    endtask

    task automatic test_pause();
        set_digits(5);
        step(4'b1110, 1'b0);
        step(4'hF, 1'b0);
        step(4'b1110, 1'b1);
        checks++;
        if (STATE !== 2'd2 || DEC_SEC !== 1'b0) begin
            failures++;
            $display("FAIL pause_with_tick state=%0d dec=%b want=2/0", STATE, DEC_SEC);
        end
        step(4'hF, 1'b0);
        step(4'b1110, 1'b0);
        checks++;
        if (STATE !== 2'd1) begin
            failures++;
            $display("FAIL resume state=%0d want=1", STATE);
        end
        step(4'hF, 1'b0);
        step(4'b1101, 1'b0);
        checks++;
        if (CLR !== 1'b1 || STATE !== 2'd0) begin
            failures++;
            $display("FAIL run_clear clr=%b state=%0d want=1/0", CLR, STATE);
        end
        step(4'hF, 1'b0);
    endtask

    task automatic test_priority_reset();
        step(4'b1001, 1'b0);
        checks++;
        if (CLR !== 1'b1 || INC_SEC !== 1'b0) begin
            failures++;
            $display("FAIL clr_over_sec clr=%b inc=%b want=1/0", CLR, INC_SEC);
        end
        step(4'hF, 1'b0);
        set_digits(5);
        step(4'b1110, 1'b0);
        step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        checks++;
        if (DEC_SEC !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_dec dec=%b want=1", DEC_SEC);
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({INC_SEC, INC_MIN, DEC_SEC, CLR, RUNNING, ALARM, BLANK, STATE} !== 9'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=0", {INC_SEC, INC_MIN, DEC_SEC, CLR, RUNNING, ALARM, BLANK, STATE});
        end
        @(negedge MCLK);
        TICK = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_random();
        int v, ms, ac, ex;
        logic ab, zero, t;
        logic [3:0] p, ev;
        logic [3:0] exp_strobe;
        do_reset();
        v = $urandom_range(0, 3);
        ms = 0;
        ac = 0;
        ab = 1'b0;
        set_digits(v);
        for (int k = 0; k < 300; k++) begin
            p = 4'd0;
            t = 1'b0;
            ex = $urandom_range(0, 99);
            if (ex < 45) t = 1'b1;
            else if (ex < 60) p[0] = 1'b1;
            else if (ex < 64) p[1] = 1'b1;
            else if (ex < 77) p[2] = 1'b1;
            else if (ex < 90) p[3] = 1'b1;
            else begin
                p = 4'($urandom_range(1, 15));
                t = 1'($urandom_range(0, 1));
            end
            zero = (v == 0);
            ev = 4'd0;
            case (ms)
                0, 2: begin
                    if (p[1]) begin ev = 4'b0001; ms = 0; end
                    else if (p[0]) ms = zero ? 0 : 1;
                    else if (p[3]) ev = (v / 100 != 99) ? 4'b0100 : 4'b0000;
                    else if (p[2]) ev = (v != 9999) ? 4'b1000 : 4'b0000;
                end
                1: begin
                    if (p[1]) begin ev = 4'b0001; ms = 0; end
                    else if (p[0]) ms = 2;
                    else if (t) begin
                        if (!zero) ev = 4'b0010;
                        if (v <= 1) begin ms = 3; ab = 1'b0; ac = 0; end
                    end
                end
                default: begin
                    if (p[1] || p[0]) begin ms = 0; ab = 1'b0; end
                    else if (t) begin
                        ac++;
                        if (ac == 10) begin ms = 0; ab = 1'b0; end
                        else ab = ~ab;
                    end else if (p[3] || p[2]) begin ms = 0; ab = 1'b0; end
                end
            endcase
            exp_strobe = ev;
            step(~p, t);
            checks++;
            if ({INC_SEC, INC_MIN, DEC_SEC, CLR, STATE, BLANK, RUNNING, ALARM} !==
                {exp_strobe, 2'(ms), ab, ms == 1, ms == 3}) begin
                failures++;
                $display("FAIL random_ev%0d p=%b t=%b v=%0d got=%b want=%b", k, p, t, v,
                    {INC_SEC, INC_MIN, DEC_SEC, CLR, STATE, BLANK, RUNNING, ALARM},
                    {exp_strobe, 2'(ms), ab, ms == 1, ms == 3});
            end
            if (ev[3]) v = v + 1;
            if (ev[2]) v = v + 100;
            if (ev[1]) v = v - 1;
            if (ev[0]) v = 0;
            set_digits(v);
            step(4'hF, 1'b0);
            checks++;
            if ({INC_SEC, INC_MIN, DEC_SEC, CLR} !== 4'd0) begin
                failures++;
                $display("FAIL random_idle%0d got=%b want=0000", k, {INC_SEC, INC_MIN, DEC_SEC, CLR});
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_alarm();
        test_alarm();
        test_repeat();
        test_pause();
        test_priority_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
